// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one word fetch at a time to a
// variable-latency memory and buffers returned words with their PCs in a small FIFO.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     fetch_pc_r, fetch_pc_s;
  logic [31:0]     pending_pc_r, pending_pc_s;
  logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic [31:0]     fifo_pc_r    [DEPTH];
  logic [31:0]     fifo_instr_r [DEPTH];
  logic            push_s, pop_s;
  logic [31:0]     redirect_aligned_s;

  // A redirect discards any same-cycle push or pop, so both are gated here.
  assign redirect_aligned_s = {redirect_pc[31:2], 2'b00};
  assign push_s       = (state_r == ST_WAIT) && imem_ack && !redirect;
  assign pop_s        = (count_r != {CW{1'b0}}) && instr_ready && !redirect;
  assign count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

  // Next-state and fetch-PC selection; an outstanding request cannot be retracted.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    pending_pc_s = pending_pc_r;
    if (redirect) begin
      if ((state_r != ST_IDLE) && !imem_ack) begin
        state_s      = ST_DROP;
        pending_pc_s = redirect_aligned_s;
      end else begin
        state_s    = ST_WAIT;
        fetch_pc_s = redirect_aligned_s;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r < FULL) state_s = ST_WAIT;
          else                state_s = ST_IDLE;
        end
        ST_WAIT: begin
          if (imem_ack) begin
            fetch_pc_s = fetch_pc_r + 32'd4;
            state_s    = (count_next_s < FULL) ? ST_WAIT : ST_IDLE;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            fetch_pc_s = pending_pc_r;
            state_s    = (count_next_s < FULL) ? ST_WAIT : ST_IDLE;
          end else begin
            state_s = ST_DROP;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Control state, PCs and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= RESET_PC;
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      pending_pc_r <= pending_pc_s;
      if (redirect) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        count_r <= count_next_s;
      end
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_pc_r[wr_ptr_r]    <= fetch_pc_r;
      fifo_instr_r[wr_ptr_r] <= imem_rdata;
    end
  end

  assign imem_req    = (state_r != ST_IDLE);
  assign imem_addr   = fetch_pc_r;
  assign instr_valid = (count_r != {CW{1'b0}});
  assign instr       = fifo_instr_r[rd_ptr_r];
  assign instr_pc    = fifo_pc_r[rd_ptr_r];
  assign count       = count_r;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model of the fetch stage.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;
  logic [CW-1:0] count;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int          checks   = 0;
  int          failures = 0;
  ent_t        q[$];
  logic        m_busy, m_stale;
  logic [31:0] m_next, m_pend;
  int          lat, lat_cnt;
  bit          scramble, rand_lat;

  function automatic logic [31:0] data_of(input logic [31:0] a, input bit scr);
    return scr ? (a ^ 32'h5A5A_5A5A) : a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory responds, model advances by the fetch rules, outputs are compared.
  task automatic cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
    logic ack, req_b, pop, push;
    int   sz;
    req_b       = (imem_req === 1'b1);
    ack         = !reset && req_b && (lat_cnt >= lat);
    imem_ack    = ack;
    imem_rdata  = ack ? data_of(imem_addr, scramble) : 32'hDEAD_BEEF;
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_next  = RESET_PC;
      m_pend  = RESET_PC;
      lat_cnt = 0;
    end else begin
      sz = q.size();
      if (rdr) begin
        q.delete();
        if (m_busy && !ack) begin
          m_stale = 1'b1;
          m_pend  = {rpc[31:2], 2'b00};
        end else begin
          m_busy  = 1'b1;
          m_stale = 1'b0;
          m_next  = {rpc[31:2], 2'b00};
        end
      end else begin
        pop  = rdy && (sz != 0);
        push = m_busy && ack && !m_stale;
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back({m_next, data_of(m_next, scramble)});
          m_next = m_next + 32'd4;
        end
        if (m_busy && ack) begin
          if (m_stale) begin
            m_stale = 1'b0;
            m_next  = m_pend;
          end
          m_busy = (q.size() < DEPTH);
        end else if (!m_busy) begin
          m_busy = (sz < DEPTH);
        end
      end
      lat_cnt = ack ? 0 : (req_b ? lat_cnt + 1 : 0);
      if (ack && rand_lat) lat = $urandom_range(0, 3);
    end
    #1;
    check("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) check("imem_addr", imem_addr, m_next);
    check("count", 32'(count), 32'(q.size()));
    check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr_pc", instr_pc, q[0].pc);
      check("instr", instr, q[0].ins);
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    lat = 0; lat_cnt = 0; scramble = 1'b0; rand_lat = 1'b0;
    m_busy = 1'b0; m_stale = 1'b0; m_next = RESET_PC; m_pend = RESET_PC;

    // Reset state and zero-wait streaming
    run(3, 1'b0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    run(1, 1'b1);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    run(12, 1'b1);
    check("stream_valid", 32'(instr_valid), 32'd1);
    check("stream_pc", instr_pc, 32'd44);
    check("stream_instr", instr, 32'd44);

    // Backpressure to full, then a single pop
    do_reset();
    run(8, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_head", instr_pc, 32'h0);
    run(1, 1'b1);
    check("pop_count", 32'(count), 32'd3);
    check("pop_head", instr_pc, 32'h4);
    check("pop_req_lo", 32'(imem_req), 32'd0);
    run(1, 1'b0);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'd16);

    // Redirect from the full/idle state
    run(3, 1'b0);
    check("refull_count", 32'(count), 32'd4);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    check("rdr_count", 32'(count), 32'd0);
    check("rdr_valid", 32'(instr_valid), 32'd0);
    check("rdr_addr", imem_addr, 32'h100);
    run(1, 1'b1);
    check("rdr_first_pc", instr_pc, 32'h100);
    check("rdr_first_valid", 32'(instr_valid), 32'd1);

    // Redirect while a slow request is outstanding
    do_reset();
    lat = 3;
    run(2, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("drop_addr0", imem_addr, 32'h0);
    check("drop_req0", 32'(imem_req), 32'd1);
    run(1, 1'b1);
    check("drop_addr1", imem_addr, 32'h0);
    run(1, 1'b1);
    check("drop_new_addr", imem_addr, 32'h200);
    check("drop_count", 32'(count), 32'd0);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) run(1, 1'b1);
    check("drop_wait_valid", 32'(instr_valid), 32'd1);
    check("drop_first_pc", instr_pc, 32'h200);

    // Same-cycle push, pop and redirect
    lat = 0;
    run(4, 1'b1);
    check("sim_pre_valid", 32'(instr_valid), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0300);
    check("sim_count", 32'(count), 32'd0);
    check("sim_valid", 32'(instr_valid), 32'd0);
    check("sim_addr", imem_addr, 32'h300);

    // Push and pop together at count 2
    do_reset();
    run(3, 1'b0);
    check("pp_pre_count", 32'(count), 32'd2);
    run(1, 1'b1);
    check("pp_count", 32'(count), 32'd2);

    // PC wrap-around
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    run(1, 1'b1);
    check("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    run(1, 1'b1);
    check("wrap_pc1", instr_pc, 32'h0000_0000);

    // Random traffic against the model
    scramble = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0)
        cycle(1'($urandom_range(0, 1)), 1'b1, 32'($urandom));
      else
        cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
